// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pkg
//  Purpose  : Shared RV32I constants: writeback source selects, load funct3
//             codes and the datapath/register-index widths.
//  Revision : 1.0  initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    // Writeback source select (encoding 3 aliases the ALU path)
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_LD  = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
//  Module   : load_extract
//  Purpose  : Combinational load-data alignment. Picks the addressed byte or
//             halfword out of a 32-bit memory word and sign/zero-extends it
//             according to the load funct3.
//  Revision : 1.0  initial release
// ============================================================================
module load_extract
    import rv32i_pkg::*;
(
    input  logic [31:0] ld_data_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection: byte by full offset, halfword by offset[1] only
    always_comb begin
        w_byte = ld_data_i[7:0];
        case (offset_i)
            2'd0: w_byte = ld_data_i[7:0];
            2'd1: w_byte = ld_data_i[15:8];
            2'd2: w_byte = ld_data_i[23:16];
            2'd3: w_byte = ld_data_i[31:24];
            default: w_byte = ld_data_i[7:0];
        endcase
        w_half = offset_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    end

    // Extension by funct3; undefined codes pass the raw word through
    always_comb begin
        data_o = ld_data_i;
        case (f3_i)
            F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  data_o = {24'd0, w_byte};
            F3_LH:   data_o = {{16{w_half[15]}}, w_half};
            F3_LHU:  data_o = {16'd0, w_half};
            F3_LW:   data_o = ld_data_i;
            default: data_o = ld_data_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : RV32I writeback stage and integer register file. Selects the
//             writeback value (ALU / extracted load / PC+4), writes x1..x31,
//             and serves two combinational read ports with write-through
//             bypass. x0 always reads zero.
//  Revision : 1.0  initial release
// ============================================================================
module wb_regfile
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_en,
    input  logic [1:0]           wb_sel,
    input  logic [REG_IDX_W-1:0] rd_index,
    input  logic [XLEN-1:0]      alu_out_in,
    input  logic [XLEN-1:0]      ld_data_in,
    input  logic [XLEN-1:0]      pc4_in,
    input  logic [2:0]           ld_f3,
    input  logic [REG_IDX_W-1:0] rs1_index,
    input  logic [REG_IDX_W-1:0] rs2_index,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic [XLEN-1:0]      wb_data
);

    // Entry 0 is never written, so it stays at its reset value of zero
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] w_ld_ext;
    logic            w_we;

    load_extract u_load_extract (
        .ld_data_i (ld_data_in),
        .offset_i  (alu_out_in[1:0]),
        .f3_i      (ld_f3),
        .data_o    (w_ld_ext)
    );

    // Writes to x0 are squashed here so both the array and the bypass ignore them
    assign w_we = wb_en && (rd_index != '0);

    // Writeback source mux; encoding 3 falls back to the ALU result
    always_comb begin
        wb_data = alu_out_in;
        case (wb_sel)
            WB_SEL_ALU: wb_data = alu_out_in;
            WB_SEL_LD:  wb_data = w_ld_ext;
            WB_SEL_PC4: wb_data = pc4_in;
            default:    wb_data = alu_out_in;
        endcase
    end

    // Register array: async clear, single write port on rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_we) begin
            regs_q[rd_index] <= wb_data;
        end
    end

    // Read port 1: zero for x0 or during reset, bypass on same-cycle write
    always_comb begin
        rs1_data = '0;
        if (!rst && (rs1_index != '0)) begin
            rs1_data = (w_we && (rd_index == rs1_index)) ? wb_data : regs_q[rs1_index];
        end
    end

    // Read port 2: identical policy to port 1
    always_comb begin
        rs2_data = '0;
        if (!rst && (rs2_index != '0)) begin
            rs2_data = (w_we && (rd_index == rs2_index)) ? wb_data : regs_q[rs2_index];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Self-checking bench for wb_regfile: reset sequences by hand,
//             then a directed vector table of writes, loads and reads.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [1:0]  wb_sel;
    logic [4:0]  rd_index;
    logic [31:0] alu_out_in;
    logic [31:0] ld_data_in;
    logic [31:0] pc4_in;
    logic [2:0]  ld_f3;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_wb;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
    } vec_t;

    vec_t vecs[$];

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .rd_index   (rd_index),
        .alu_out_in (alu_out_in),
        .ld_data_in (ld_data_in),
        .pc4_in     (pc4_in),
        .ld_f3      (ld_f3),
        .rs1_index  (rs1_index),
        .rs2_index  (rs2_index),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_data    (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] ld,
                                input logic [31:0] pc4, input logic [2:0] f3,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] e_wb, input logic [31:0] e_rs1,
                                input logic [31:0] e_rs2);
        vec_t v;
        v.we = we; v.sel = sel; v.rd = rd; v.alu = alu; v.ld = ld; v.pc4 = pc4;
        v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2;
        v.e_wb = e_wb; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
        return v;
    endfunction

    initial begin
        // Vector table: inputs are applied after a falling edge, outputs are
        // checked 1 time unit later, and the following rising edge commits writes.
        //            we    sel   rd     alu           ld            pc4           f3    rs1    rs2    wb            rs1           rs2
        vecs.push_back(mk(1'b1, 2'd0, 5'd3,  32'hDEADBEEF, 32'h0,        32'h0,        3'd2, 5'd3,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b0, 2'd0, 5'd3,  32'h0,        32'h0,        32'h0,        3'd2, 5'd0,  5'd3,  32'h0,        32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h3,        32'h80FF7F01, 32'h0,        3'd0, 5'd3,  5'd3,  32'hFFFFFF80, 32'hDEADBEEF, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h3,        32'h80FF7F01, 32'h0,        3'd4, 5'd3,  5'd0,  32'h00000080, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h2,        32'h80FF7F01, 32'h0,        3'd1, 5'd0,  5'd0,  32'hFFFF80FF, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h0,        32'h80FF7F01, 32'h0,        3'd5, 5'd0,  5'd0,  32'h00007F01, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h3,        32'h80FF7F01, 32'h0,        3'd2, 5'd0,  5'd0,  32'h80FF7F01, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h1,        32'h80FF7F01, 32'h0,        3'd0, 5'd0,  5'd0,  32'h0000007F, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h3,        32'h80FF7F01, 32'h0,        3'd1, 5'd0,  5'd0,  32'hFFFF80FF, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h1,        32'h80FF7F01, 32'h0,        3'd3, 5'd0,  5'd0,  32'h80FF7F01, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'd1, 5'd0,  32'h2,        32'h80FF7F01, 32'h0,        3'd5, 5'd0,  5'd0,  32'h000080FF, 32'h0,        32'h0));
        vecs.push_back(mk(1'b1, 2'd1, 5'd4,  32'h0,        32'h80FF7F01, 32'h0,        3'd0, 5'd4,  5'd3,  32'h00000001, 32'h00000001, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 2'd0, 5'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        3'd2, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        32'h0));
        vecs.push_back(mk(1'b0, 2'd0, 5'd0,  32'h0,        32'h0,        32'h0,        3'd2, 5'd0,  5'd4,  32'h0,        32'h0,        32'h00000001));
        vecs.push_back(mk(1'b1, 2'd2, 5'd1,  32'h55,       32'h0,        32'h00000104, 3'd2, 5'd1,  5'd1,  32'h00000104, 32'h00000104, 32'h00000104));
        vecs.push_back(mk(1'b0, 2'd0, 5'd1,  32'hAAAAAAAA, 32'h0,        32'h0,        3'd2, 5'd1,  5'd3,  32'hAAAAAAAA, 32'h00000104, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 2'd0, 5'd0,  32'h0,        32'h0,        32'h0,        3'd2, 5'd1,  5'd0,  32'h0,        32'h00000104, 32'h0));
        vecs.push_back(mk(1'b1, 2'd3, 5'd31, 32'h13579BDF, 32'h0,        32'h0,        3'd2, 5'd31, 5'd1,  32'h13579BDF, 32'h13579BDF, 32'h00000104));
        vecs.push_back(mk(1'b0, 2'd0, 5'd0,  32'h0,        32'h0,        32'h0,        3'd2, 5'd31, 5'd31, 32'h0,        32'h13579BDF, 32'h13579BDF));

        // ---- Power-on reset: reads gated to 0, wb_data still combinational
        rst = 1'b1; wb_en = 1'b0; wb_sel = 2'd0; rd_index = 5'd0;
        alu_out_in = 32'hCAFEF00D; ld_data_in = 32'h0; pc4_in = 32'h0; ld_f3 = 3'd2;
        rs1_index = 5'd5; rs2_index = 5'd31;
        #1;
        chk("reset rs1", rs1_data, 32'h0);
        chk("reset rs2", rs2_data, 32'h0);
        chk("reset wb_data", wb_data, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- Preload x5, then pulse reset mid-cycle
        wb_en = 1'b1; rd_index = 5'd5; alu_out_in = 32'h12345678; wb_sel = 2'd0;
        @(negedge clk);
        wb_en = 1'b0; alu_out_in = 32'h0; rs1_index = 5'd5;
        #1;
        chk("preload x5", rs1_data, 32'h12345678);
        #2 rst = 1'b1;
        #1;
        chk("mid-cycle rst x5", rs1_data, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("after rst x5", rs1_data, 32'h0);

        // ---- Reset coincident with a write edge: reset wins
        @(negedge clk);
        wb_en = 1'b1; rd_index = 5'd7; alu_out_in = 32'h77777777; wb_sel = 2'd0;
        rs1_index = 5'd7; rst = 1'b1;
        #1;
        chk("collision rs1 during rst", rs1_data, 32'h0);
        chk("collision wb_data", wb_data, 32'h77777777);
        @(negedge clk);
        rst = 1'b0; wb_en = 1'b0; alu_out_in = 32'h0;
        #1;
        chk("collision x7 after release", rs1_data, 32'h0);

        // ---- Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wb_en = vecs[i].we; wb_sel = vecs[i].sel; rd_index = vecs[i].rd;
            alu_out_in = vecs[i].alu; ld_data_in = vecs[i].ld; pc4_in = vecs[i].pc4;
            ld_f3 = vecs[i].f3; rs1_index = vecs[i].rs1; rs2_index = vecs[i].rs2;
            #1;
            chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_wb);
            chk($sformatf("v%0d rs1_data", i), rs1_data, vecs[i].e_rs1);
            chk($sformatf("v%0d rs2_data", i), rs2_data, vecs[i].e_rs2);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs (alu_out, ld_data).
- Extracts and sign- or zero-extends load data, then selects the writeback source.
- Writes the RV32I integer register file (x0..x31, x0 hardwired to zero).
- Two combinational read ports serve the decode stage, with same-cycle write-through bypass. The selected writeback value is exported for forwarding.

Parameters:
- XLEN, 32, data width of registers and datapath.
- NREG, 32, number of architectural registers; index width is log2(NREG)=5.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_en  input  1  register write enable from the W-stage control.
- wb_sel  input  2  writeback source: 0=ALU, 1=load, 2=PC+4, 3=ALU.
- rd_index  input  5  destination register index.
- alu_out_in  input  XLEN  ALU result from the MEM/WB register; bits [1:0] are the load byte offset.
- ld_data_in  input  XLEN  raw 32-bit memory word from the MEM/WB register.
- pc4_in  input  XLEN  PC+4 for JAL/JALR.
- ld_f3  input  3  load funct3: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
- rs1_index  input  5  read port 1 index.
- rs2_index  input  5  read port 2 index.
- rs1_data  output  XLEN  read port 1 data.
- rs2_data  output  XLEN  read port 2 data.
- wb_data  output  XLEN  selected writeback value; combinational; for forwarding.

Behaviour:
- Reset:
  - rst high asynchronously clears x1..x31 to 0.
  - While rst is high, writes are blocked, and rs1_data and rs2_data read 0 for every index.
  - wb_data stays combinational from its inputs during reset.
- Load extraction, combinational, offset = alu_out_in[1:0]:
  - LB and LBU select byte ld_data_in[8*offset+7 : 8*offset]. LB sign-extends bit 7; LBU zero-extends.
  - LH and LHU select the halfword chosen by offset[1] (0 = [15:0], 1 = [31:16]); offset[0] is ignored. LH sign-extends bit 15; LHU zero-extends.
  - LW passes ld_data_in unchanged and ignores the offset.
  - Undefined funct3 values (3, 6, 7) pass ld_data_in unchanged.
- Writeback mux, combinational: wb_data = ALU (sel 0 or 3), extracted load (sel 1), or pc4_in (sel 2).
- Write:
  - At a rising clk with rst low, wb_en=1 and rd_index!=0, regs[rd_index] <= wb_data.
  - Any write to index 0 is discarded.
  - Write latency is one edge: the written value is visible in the array from the next cycle.
- Read, combinational:
  - rsN_data = 0 if rsN_index==0.
  - Otherwise rsN_data = wb_data if wb_en && rd_index!=0 && rd_index==rsN_index (write-through bypass; same-cycle write-then-read returns the new value).
  - Otherwise rsN_data = regs[rsN_index].
- Simultaneous events:
  - rs1 and rs2 with the same index both receive the identical value, including the bypass value.
  - Reset asserted coincident with a write edge: reset wins and the register stays 0.
  - Reset deasserting mid-cycle: the first write occurs on the next rising edge.
- No stall input. The W stage always retires; bubbles arrive as wb_en=0.

Decomposition:
- Shared package (rv32i_pkg), constants:
  - WB_SEL_ALU=2'd0, WB_SEL_LD=2'd1, WB_SEL_PC4=2'd2.
  - F3_LB=3'd0, F3_LH=3'd1, F3_LW=3'd2, F3_LBU=3'd4, F3_LHU=3'd5.
  - XLEN and REG_IDX_W=5.
- One sub-module, load_extract:
  - Purely combinational.
  - Inputs: ld_data, offset[1:0], f3.
  - Output: the extended 32-bit word.
  - Reused later by the memory-side alignment logic.
- The register array, bypass and writeback mux stay in wb_regfile.

Test Plan:
- Reset: preload x5=0x12345678, pulse rst mid-cycle (not edge-aligned) -> rs1_data for x5 is 0 immediately and stays 0 after rst falls.
- ALU write/read:
  - Write x3 with wb_sel=0, alu_out_in=0xDEADBEEF -> next cycle rs2_data(x3)=0xDEADBEEF.
  - Same cycle with rs1_index=3 -> rs1_data=0xDEADBEEF via bypass.
- Load extraction with ld_data_in=0x80FF7F01:
  - LB, offset 3 -> 0xFFFFFF80.
  - LBU, offset 3 -> 0x00000080.
  - LH, offset 2 -> 0xFFFF80FF.
  - LHU, offset 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- x0 protection: wb_en=1, rd_index=0, wb_sel=0, alu_out_in=0xFFFFFFFF -> rs1_data(x0)=0 in the same cycle and the next cycle, no bypass.
- PC+4 and disabled write:
  - wb_sel=2, pc4_in=0x00000104 to x1 -> x1=0x00000104.
  - Then wb_en=0 with a different value -> x1 unchanged, no bypass.
- Reset versus write collision: rst high across a rising edge with wb_en=1, rd=7 -> x7 reads 0 after release.
